// File: rtl/alu_res_station.sv
// Compacting ALU/branch reservation station: oldest-ready issue, CDB wake-up, shift-down on issue.
// Optional macro RS_WAKEUP_BYPASS_EN lets a same-cycle CDB match make a slot ready (0-cycle wake-up).

package tomasula_types;
    localparam int TAG_W = 3;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [31:0]      pc;
        logic             src1_valid;
        logic [TAG_W-1:0] src1_tag;
        logic [31:0]      src1_data;
        logic             src2_valid;
        logic [TAG_W-1:0] src2_tag;
        logic [31:0]      src2_data;
        logic [TAG_W-1:0] rd_tag;
    } res_word;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [31:0]      src1_data;
        logic [31:0]      src2_data;
        logic [31:0]      pc;
        logic [TAG_W-1:0] tag;
    } alu_word;
endpackage

module alu_res_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     load,
    input  tomasula_types::res_word  load_word,
    output logic                     full,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [31:0]              cdb_data,
    output logic                     alu_valid,
    input  logic                     alu_ready,
    output tomasula_types::alu_word  alu_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    tomasula_types::res_word slot   [DEPTH];
    tomasula_types::res_word woken  [DEPTH];
    tomasula_types::res_word slot_n [DEPTH];

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after;
    logic [CNT_W-1:0] count_n;
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    logic [IDX_W-1:0] sel;
    logic             issue;
    logic             load_ok;

    // Capture a CDB broadcast into any still-missing operand of w.
    function automatic tomasula_types::res_word wake(
        input tomasula_types::res_word w,
        input logic                    v,
        input logic [TAG_W-1:0]        t,
        input logic [31:0]             d
    );
        tomasula_types::res_word r;
        r = w;
        if (v && !w.src1_valid && w.src1_tag == t) begin
            r.src1_valid = 1'b1;
            r.src1_data  = d;
        end
        if (v && !w.src2_valid && w.src2_tag == t) begin
            r.src2_valid = 1'b1;
            r.src2_data  = d;
        end
        return r;
    endfunction

    // Busy slots are contiguous from slot 0, so the busy vector follows from count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy[i]  = (CNT_W'(i) < count);
            woken[i] = wake(slot[i], cdb_valid, cdb_tag, cdb_data);
`ifdef RS_WAKEUP_BYPASS_EN
            ready[i] = busy[i] && woken[i].src1_valid && woken[i].src2_valid;
`else
            ready[i] = busy[i] && slot[i].src1_valid && slot[i].src2_valid;
`endif
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        logic found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !found) begin
                sel   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    assign alu_valid = |ready;
    assign full      = (count == CNT_W'(DEPTH));

    // Woken data equals registered data for a registered-ready slot, so one path serves both builds.
    always_comb begin
        alu_o = '0;
        if (alu_valid) begin
            alu_o.opcode    = woken[sel].opcode;
            alu_o.funct3    = woken[sel].funct3;
            alu_o.funct7    = woken[sel].funct7;
            alu_o.src1_data = woken[sel].src1_data;
            alu_o.src2_data = woken[sel].src2_data;
            alu_o.pc        = woken[sel].pc;
            alu_o.tag       = woken[sel].rd_tag;
        end
    end

    assign issue       = alu_valid && alu_ready;
    assign load_ok     = load && !full;
    assign count_after = count - CNT_W'(issue);
    assign count_n     = count_after + CNT_W'(load_ok);

    // Slots above the issued one shift down; the load lands just past the surviving entries.
    always_comb begin
        int src_idx;
        for (int i = 0; i < DEPTH; i++) begin
            src_idx = i;
            if (issue && CNT_W'(i) >= CNT_W'(sel) && i < DEPTH - 1)
                src_idx = i + 1;
            slot_n[i] = woken[src_idx];
            if (load_ok && CNT_W'(i) == count_after)
                slot_n[i] = wake(load_word, cdb_valid, cdb_tag, cdb_data);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst || flush)
            count <= '0;
        else
            count <= count_n;
    end

    // NOTE: slot payload is deliberately not reset; count marks which slots hold live data.
    always_ff @(posedge clk) begin
        slot <= slot_n;
    end
endmodule
